// File: rtl/estagio_busca.sv
// Instruction fetch stage: drives the PC to instruction memory and registers
// the fetched word into IF/ID, honouring stall, redirect and address-error conditions.
module estagio_busca #(
    parameter int          TAMANHO_MEM = 32,
    parameter logic [31:0] PC_INICIAL  = 32'd0,
    parameter logic [31:0] INSTR_BOLHA = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao,
    input  logic        parar,
    input  logic        desviar,
    input  logic [31:0] endereco_desvio,
    output logic [31:0] if_id_instrucao,
    output logic [31:0] if_id_pc,
    output logic        if_id_valido,
    output logic        erro_endereco,
    output logic [31:0] contador_busca
);

    typedef enum logic [1:0] {INICIO, BUSCA, ESPERA, ERRO} estado_t;

    localparam logic [31:0] LIMITE = 32'(TAMANHO_MEM);

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic [31:0] cont_q, cont_d;
    logic [31:0] pc_mais_um;

    function automatic logic em_faixa(input logic [31:0] a);
        return a < LIMITE;
    endfunction

    assign pc_mais_um = pc_q + 32'd1;

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        valido_d = valido_q;
        erro_d   = erro_q;
        cont_d   = cont_q;

        // A redirect overrides stall and sequential fetch in every state.
        if (desviar) begin
            pc_d     = endereco_desvio;
            valido_d = 1'b0;
            instr_d  = INSTR_BOLHA;
            if (em_faixa(endereco_desvio)) begin
                estado_d = BUSCA;
                erro_d   = 1'b0;
            end else begin
                estado_d = ERRO;
                erro_d   = 1'b1;
            end
        end else begin
            case (estado_q)
                INICIO: begin
                    if (em_faixa(pc_q)) begin
                        estado_d = BUSCA;
                    end else begin
                        estado_d = ERRO;
                        erro_d   = 1'b1;
                    end
                end
                BUSCA, ESPERA: begin
                    if (parar) begin
                        estado_d = ESPERA;
                    end else begin
                        // Leaving ESPERA fetches immediately, so the held PC is neither skipped nor repeated.
                        instr_d  = instrucao;
                        ifpc_d   = pc_mais_um;
                        valido_d = 1'b1;
                        pc_d     = pc_mais_um;
                        cont_d   = cont_q + 32'd1;
                        if (em_faixa(pc_mais_um)) begin
                            estado_d = BUSCA;
                        end else begin
                            estado_d = ERRO;
                            erro_d   = 1'b1;
                        end
                    end
                end
                ERRO: begin
                    valido_d = 1'b0;
                    instr_d  = INSTR_BOLHA;
                    erro_d   = 1'b1;
                end
                default: begin
                    estado_d = INICIO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= INICIO;
            pc_q     <= PC_INICIAL;
            instr_q  <= INSTR_BOLHA;
            ifpc_q   <= 32'd0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            cont_q   <= 32'd0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            cont_q   <= cont_d;
        end
    end

    assign endereco        = pc_q;
    assign if_id_instrucao = instr_q;
    assign if_id_pc        = ifpc_q;
    assign if_id_valido    = valido_q;
    assign erro_endereco   = erro_q;
    assign contador_busca  = cont_q;

endmodule

// File: doc/estagio_busca.md
ESTAGIO_BUSCA -- requirements
Module: estagio_busca

Interface
REQ-001 The block SHALL have parameter TAMANHO_MEM, default 32, the number of instruction words addressable; the valid index range is 0..TAMANHO_MEM-1.
REQ-002 The block SHALL have parameter PC_INICIAL, default 32'd0, the first fetch index after reset.
REQ-003 The block SHALL have parameter INSTR_BOLHA, default 32'h00000000, the bubble word placed in IF/ID when no valid instruction is held.
REQ-004 The block SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port endereco  out  32  word index driven to instruction memory; equals the PC register, combinational from it.
REQ-007 The block SHALL have port instrucao  in  32  word returned by instruction memory for endereco, valid in the same cycle.
REQ-008 The block SHALL have port parar  in  1  stall request from hazard logic.
REQ-009 The block SHALL have port desviar  in  1  redirect request (jump/branch/call/return taken).
REQ-010 The block SHALL have port endereco_desvio  in  32  redirect target word index, sampled when desviar=1.
REQ-011 The block SHALL have port if_id_instrucao  out  32  registered fetched instruction.
REQ-012 The block SHALL have port if_id_pc  out  32  registered index of the next sequential instruction (fetch index + 1).
REQ-013 The block SHALL have port if_id_valido  out  1  IF/ID register holds a real instruction.
REQ-014 The block SHALL have port erro_endereco  out  1  fetch index outside 0..TAMANHO_MEM-1.
REQ-015 The block SHALL have port contador_busca  out  32  count of instructions delivered valid into IF/ID.

Function
REQ-016 The block SHALL implement states INICIO, BUSCA, ESPERA, ERRO.
REQ-017 INICIO SHALL last exactly one cycle after reset release: PC held, IF/ID kept invalid, then -> BUSCA (or ERRO if PC_INICIAL >= TAMANHO_MEM).
REQ-018 In BUSCA each cycle with parar=0, desviar=0 SHALL load if_id_instrucao<=instrucao, if_id_pc<=PC+1, if_id_valido<=1, PC<=PC+1, contador_busca<=contador_busca+1.
REQ-019 In BUSCA with parar=1, desviar=0 the block SHALL hold PC and all IF/ID outputs unchanged and go to ESPERA.
REQ-020 In ESPERA the block SHALL hold PC, IF/ID and contador_busca while parar=1 and return to BUSCA the cycle after parar=0 is sampled, with no instruction lost or duplicated.
REQ-021 Priority SHALL be reset_n > desviar > parar > sequential fetch, in every state.
REQ-022 On desviar=1 the block SHALL load PC<=endereco_desvio, set if_id_valido<=0, if_id_instrucao<=INSTR_BOLHA, leave contador_busca unchanged, and go to BUSCA (target in range) or ERRO (target out of range).
REQ-023 A PC increment reaching TAMANHO_MEM SHALL enter ERRO on the next edge; no wrap to 0.
REQ-024 In ERRO the block SHALL hold PC, drive if_id_valido=0 and if_id_instrucao=INSTR_BOLHA, and assert erro_endereco=1; only desviar to an in-range target exits (to BUSCA, erro_endereco cleared same edge).
REQ-025 contador_busca SHALL wrap modulo 2^32.
REQ-026 endereco SHALL never be driven with a value >= TAMANHO_MEM outside ERRO.

Reset
REQ-027 While reset_n=0, asynchronously: state=INICIO, PC=PC_INICIAL, if_id_instrucao=INSTR_BOLHA, if_id_pc=0, if_id_valido=0, erro_endereco=0, contador_busca=0.
REQ-028 Reset asserted mid-stall, mid-redirect or in ERRO SHALL discard all state and apply REQ-027 immediately.

Verification
REQ-029 Reset release, memory[0]=32'hFFFFFFFF, memory[1]=32'h38100003, no parar/desviar -> cycle 1 INICIO invalid; cycle 2 if_id_instrucao=32'hFFFFFFFF, if_id_pc=1; cycle 3 32'h38100003, if_id_pc=2; contador_busca=2.
REQ-030 parar=1 for 3 cycles at PC=4 -> endereco stays 4, IF/ID frozen 3 cycles; first cycle after release captures memory[4], if_id_pc=5.
REQ-031 desviar=1 with endereco_desvio=13 and parar=1 same cycle -> next edge PC=13, if_id_valido=0, INSTR_BOLHA; following edge captures memory[13], if_id_pc=14.
REQ-032 Sequential run to PC=31 -> memory[31] captured, then ERRO: erro_endereco=1, if_id_valido=0, endereco=32; desviar to 0 -> erro_endereco=0, fetch resumes at 0.
REQ-033 desviar to endereco_desvio=40 -> ERRO with erro_endereco=1 next edge; reset_n pulse low mid-ERRO -> all outputs per REQ-027 without a clock edge.
